scan_chain_driver: RTL and testbench
====================================

# scan_chain_driver

Host-side master for the processor scan chain: it shifts a new state image into the chain and captures the old image coming out, in the same pass. It sits between the byte-wide host I/O path and the `scan_enable` / `scan_in` / `scan_out` pins of the control unit, register file and memory shift registers. While a session is active it holds the processor via `cpu_hold`, so the chain contents never change under execution.

## Interface
Parameters:
- `CHAIN_LEN`, default 40: total number of flops in the scan chain; must be at least 1.
- `CNT_W`, default 6: width of the chain bit counter; must satisfy 2^`CNT_W` > `CHAIN_LEN`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: begins a session. Sampled only in IDLE; ignored at all other times.
- `busy` out 1: high in every state except IDLE.
- `cpu_hold` out 1: identical to `busy`. The top level ANDs its inverse into `processor_enable`.
- `done` out 1: one-cycle pulse when a session completes.
- `in_data` in 8: next image byte to shift into the chain, consumed LSB first.
- `in_valid` in 1 / `in_ready` out 1: handshake for `in_data`.
- `out_data` out 8: captured chain byte.
- `out_valid` out 1 / `out_ready` in 1: handshake for `out_data`.
- `scan_enable` out 1: drives the chain's shift enable.
- `scan_in` out 1: drives the chain's serial input.
- `scan_out` in 1: the chain's serial output.

## Operation
- The state machine has five states: IDLE, LOAD, SHIFT, PUSH, FIN.
- IDLE:
  - Moves to LOAD when `start` is high.
  - On that transition, clears the remaining-bit counter to `CHAIN_LEN` and clears the out byte.
- LOAD:
  - `in_ready` is high.
  - When `in_valid && in_ready`, latch `in_data` into the shift byte.
  - Set `nbits` = min(8, remaining) and go to SHIFT.
- SHIFT:
  - Lasts exactly `nbits` cycles, with `scan_enable` = 1 on each of them.
  - On shift cycle k (k = 0..nbits-1):
    - `scan_in` = shift byte bit k.
    - `scan_out` is sampled on that cycle's rising edge (the pre-shift value) into out byte bit k.
  - Out-byte bits at positions ≥ `nbits` are 0.
  - Remaining decrements by 1 per shift cycle.
  - After the last shift cycle, go to PUSH.
- PUSH:
  - `out_valid` is high and `out_data` holds the captured byte.
  - When `out_ready` is high: if remaining > 0, go to LOAD with the out byte cleared; otherwise go to FIN.
- FIN: `done` = 1 for one cycle, then return to IDLE.
- Bit ordering: chain bit 0, the first bit shifted out, is `out_data[0]` of the first byte. Total bytes exchanged = ceil(`CHAIN_LEN`/8). The last byte is partial when `CHAIN_LEN` is not a multiple of 8.
- `scan_enable` is never high outside SHIFT. Outside SHIFT, `scan_in` = 0.
- `in_ready` and `out_valid` are never high at the same time.
- Any `start` pulse while `busy` is high has no effect.

## Timing
- Reset values, also asserted asynchronously mid-session:
  - State is IDLE.
  - `busy`, `cpu_hold`, `done`, `in_ready`, `out_valid`, `scan_enable`, `scan_in` are all 0.
  - `out_data` = 0.
  - No partial byte is retained.
- Outputs are registered or decoded from registered state only. There is no combinational path from `in_valid`/`out_ready` to `in_ready`/`out_valid`.
- `start` seen on edge t: `busy` and `in_ready` are high from t+1.
- With the host always valid/ready, each byte costs 1 LOAD + `nbits` SHIFT + 1 PUSH cycles. `done` rises one cycle after the last PUSH handshake.
- Host stalls (`in_valid` low in LOAD, `out_ready` low in PUSH) hold the state indefinitely, with `scan_enable` = 0 throughout. The chain therefore does not move during stalls.
- `cpu_hold` is high from the cycle after `start` through the FIN cycle inclusive, and drops together with `busy`.

## Test plan
- `CHAIN_LEN`=16, chain model preloaded with 0xBEEF (bit 0 = 1):
  - Stimulus: `start`, feed 0x34 then 0x12 with the host always ready.
  - Required response: out bytes 0xEF then 0xBE; chain afterwards holds 0x1234.
  - Required timing: `scan_enable` high for exactly 16 cycles total; `done` pulses once, 21 cycles after `start`.
- `CHAIN_LEN`=12, chain preloaded with 0xA5C:
  - Stimulus: feed 0xFF then 0x03.
  - Required response: second byte shifts only 4 cycles; out bytes 0x5C then 0x0A; chain = 0x3FF.
- Stall test:
  - Stimulus: hold `in_valid` low for 5 cycles in LOAD, then hold `out_ready` low for 7 cycles in PUSH.
  - Required response: `scan_enable` stays 0 throughout both stalls; chain contents are unchanged during the stalls; the final image is still correct.
- Mid-SHIFT reset:
  - Stimulus: assert `rst` on shift cycle 3.
  - Required response: `scan_enable`, `busy`, `cpu_hold` drop without waiting for a clock edge.
  - Follow-up: a new `start` runs a full, correct session.
- `start` while `busy`:
  - Stimulus: pulse `start` during SHIFT and again during PUSH.
  - Required response: byte count and `done` timing are identical to a clean session; no second session begins.
- Handshake invariants, checked by assertions over a random valid/ready session:
  - `in_ready` && `out_valid` never both high.
  - `scan_enable` high only in SHIFT.
  - `done` high for exactly one cycle per session.

Source files
------------

// File: rtl/scan_chain_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scan_chain_driver: host-side scan chain master, byte-wide exchange of     |
// | the chain image (shift new image in, capture old image out).             |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module scan_chain_driver #(
  parameter int CHAIN_LEN = 40,
  parameter int CNT_W     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       cpu_hold,
  output logic       done,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       scan_enable,
  output logic       scan_in,
  input  logic       scan_out
);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_load  = 3'd1;
  localparam logic [2:0] c_st_shift = 3'd2;
  localparam logic [2:0] c_st_push  = 3'd3;
  localparam logic [2:0] c_st_fin   = 3'd4;

  localparam logic [CNT_W-1:0] c_chain_len = CNT_W'(CHAIN_LEN);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_remaining;
  logic [7:0]       r_shift_byte;
  logic [7:0]       r_out_byte;
  logic [3:0]       r_nbits;
  logic [2:0]       r_bit_idx;

  logic [3:0]       w_load_nbits;
  logic             w_last_shift;

  // Comparison done at 32 bits so narrow counters never truncate the constant 8
  assign w_load_nbits = (32'(r_remaining) >= 32'd8) ? 4'd8 : 4'(r_remaining);
  assign w_last_shift = ({1'b0, r_bit_idx} == (r_nbits - 4'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= c_st_idle;
      r_remaining  <= '0;
      r_shift_byte <= '0;
      r_out_byte   <= '0;
      r_nbits      <= '0;
      r_bit_idx    <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_state     <= c_st_load;
            r_remaining <= c_chain_len;
            r_out_byte  <= '0;
          end
        end
        c_st_load: begin
          if (in_valid) begin
            r_shift_byte <= in_data;
            r_nbits      <= w_load_nbits;
            r_bit_idx    <= '0;
            r_state      <= c_st_shift;
          end
        end
        c_st_shift: begin
          // scan_out is the pre-shift chain bit, captured on the edge that shifts it away
          r_out_byte[r_bit_idx] <= scan_out;
          r_shift_byte          <= {1'b0, r_shift_byte[7:1]};
          r_remaining           <= r_remaining - CNT_W'(1);
          r_bit_idx             <= r_bit_idx + 3'd1;
          if (w_last_shift) begin
            r_state <= c_st_push;
          end
        end
        c_st_push: begin
          if (out_ready) begin
            if (r_remaining != '0) begin
              r_state    <= c_st_load;
              r_out_byte <= '0;
            end else begin
              r_state <= c_st_fin;
            end
          end
        end
        c_st_fin: begin
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  // All outputs decode the registered state only; no handshake input feeds them
  assign busy        = (r_state != c_st_idle);
  assign cpu_hold    = busy;
  assign done        = (r_state == c_st_fin);
  assign in_ready    = (r_state == c_st_load);
  assign out_valid   = (r_state == c_st_push);
  assign out_data    = r_out_byte;
  assign scan_enable = (r_state == c_st_shift);
  assign scan_in     = scan_enable & r_shift_byte[0];

endmodule
`default_nettype wire

// File: tb/tb_scan_chain_driver.sv
`default_nettype none
// Bench for scan_chain_driver: two instances (16-bit and 12-bit chains) behind a
// shared host model, directed table, hand-written corner sequences, random sessions.
module tb_scan_chain_driver;

  logic clk;
  logic rst;
  logic sel;
  logic start;
  logic [7:0] in_data;
  logic in_valid;
  logic out_ready;
  logic load_req;
  logic [15:0] load_val;

  logic busy_a, cpu_hold_a, done_a, in_ready_a, out_valid_a, scan_enable_a, scan_in_a, scan_out_a;
  logic busy_b, cpu_hold_b, done_b, in_ready_b, out_valid_b, scan_enable_b, scan_in_b, scan_out_b;
  logic [7:0] out_data_a, out_data_b;
  logic start_a, start_b;
  logic [15:0] chain_a, chain_b;

  logic busy, cpu_hold, done, in_ready, out_valid, scan_enable, scan_in;
  logic [7:0] out_data;
  logic [15:0] cur_chain;

  int checks;
  int errors;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  scan_chain_driver #(.CHAIN_LEN(16), .CNT_W(5)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .cpu_hold(cpu_hold_a),
    .done(done_a), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .scan_enable(scan_enable_a), .scan_in(scan_in_a), .scan_out(scan_out_a)
  );

  scan_chain_driver #(.CHAIN_LEN(12), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .cpu_hold(cpu_hold_b),
    .done(done_b), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .scan_enable(scan_enable_b), .scan_in(scan_in_b), .scan_out(scan_out_b)
  );

  // Chain models: serial input enters at the top, bit 0 leaves first
  always @(posedge clk) begin
    if (load_req && !sel) chain_a <= load_val;
    else if (scan_enable_a) chain_a <= {scan_in_a, chain_a[15:1]};
    if (load_req && sel) chain_b <= {4'b0, load_val[11:0]};
    else if (scan_enable_b) chain_b <= {4'b0, scan_in_b, chain_b[11:1]};
  end
  assign scan_out_a = chain_a[0];
  assign scan_out_b = chain_b[0];

  assign busy        = sel ? busy_b        : busy_a;
  assign cpu_hold    = sel ? cpu_hold_b    : cpu_hold_a;
  assign done        = sel ? done_b        : done_a;
  assign in_ready    = sel ? in_ready_b    : in_ready_a;
  assign out_valid   = sel ? out_valid_b   : out_valid_a;
  assign scan_enable = sel ? scan_enable_b : scan_enable_a;
  assign scan_in     = sel ? scan_in_b     : scan_in_a;
  assign out_data    = sel ? out_data_b    : out_data_a;
  assign cur_chain   = sel ? chain_b       : chain_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  a_hs_a: assert property (@(posedge clk) disable iff (rst) !(in_ready_a && out_valid_a))
    else begin errors++; $display("FAIL assert_handshake_a in_ready=1 out_valid=1 required not both"); end
  a_hs_b: assert property (@(posedge clk) disable iff (rst) !(in_ready_b && out_valid_b))
    else begin errors++; $display("FAIL assert_handshake_b in_ready=1 out_valid=1 required not both"); end
  a_se_a: assert property (@(posedge clk) disable iff (rst)
      scan_enable_a |-> (busy_a && !in_ready_a && !out_valid_a && !done_a))
    else begin errors++; $display("FAIL assert_se_only_shift_a scan_enable=1 outside shift"); end
  a_se_b: assert property (@(posedge clk) disable iff (rst)
      scan_enable_b |-> (busy_b && !in_ready_b && !out_valid_b && !done_b))
    else begin errors++; $display("FAIL assert_se_only_shift_b scan_enable=1 outside shift"); end
  a_done_a: assert property (@(posedge clk) disable iff (rst) done_a |=> !done_a)
    else begin errors++; $display("FAIL assert_done_pulse_a done high two cycles"); end
  a_done_b: assert property (@(posedge clk) disable iff (rst) done_b |=> !done_b)
    else begin errors++; $display("FAIL assert_done_pulse_b done high two cycles"); end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [15:0] v);
    load_val = v;
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  // Drives one session as the host; edone < 0 skips the cycle-exact done timing check
  task automatic run_session(input logic s, input logic [15:0] pre, input logic [15:0] img,
                             input int in_stall, input int out_stall, input bit poke, input bit rnd,
                             input logic [7:0] e0, input logic [7:0] e1, input logic [15:0] eimg,
                             input int ese, input int edone, input string name);
    logic [7:0] eo [2];
    logic [15:0] prev_chain;
    int in_idx, out_idx, se_cnt, done_at, wait_cnt, shift_seen, push_seen;
    bit stall, prev_stall;
    eo[0] = e0; eo[1] = e1;
    in_idx = 0; out_idx = 0; se_cnt = 0; done_at = -1; wait_cnt = 0;
    shift_seen = 0; push_seen = 0; prev_stall = 0; prev_chain = '0;
    sel = s; in_valid = 0; out_ready = 0;
    preload(pre);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_busy_after_start"}, busy, 1);
    check({name, "_in_ready_after_start"}, in_ready, 1);
    for (int c = 1; c <= 400 && done_at < 0; c++) begin
      in_valid = 0; out_ready = 0; start = 0; stall = 0;
      check({name, "_cpu_hold_eq_busy"}, cpu_hold, busy);
      if (scan_enable) begin
        se_cnt++; shift_seen++;
        if (poke && shift_seen == 3) start = 1;
      end else begin
        check({name, "_scan_in_idle"}, scan_in, 0);
      end
      if (done) done_at = c;
      if (in_ready) begin
        in_valid = rnd ? ($urandom_range(0, 2) != 0) : (wait_cnt >= in_stall);
        if (in_valid && in_idx < 2) begin
          in_data = img[8*in_idx +: 8];
          in_idx++;
          wait_cnt = 0;
        end else begin
          in_valid = 0; stall = 1; wait_cnt++;
        end
      end
      if (out_valid) begin
        push_seen++;
        if (poke && push_seen == 1) start = 1;
        out_ready = rnd ? ($urandom_range(0, 2) != 0) : (wait_cnt >= out_stall);
        if (out_ready) begin
          if (out_idx < 2) check({name, "_out_byte"}, out_data, eo[out_idx]);
          out_idx++;
          wait_cnt = 0;
        end else begin
          stall = 1; wait_cnt++;
        end
      end
      if (stall) check({name, "_stall_scan_enable"}, scan_enable, 0);
      if (stall && prev_stall) check({name, "_stall_chain_frozen"}, cur_chain, prev_chain);
      prev_stall = stall;
      prev_chain = cur_chain;
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 0; start = 0;
    check({name, "_done_seen"}, (done_at >= 0), 1);
    if (edone >= 0) check({name, "_done_cycle"}, done_at, edone);
    check({name, "_bytes_in"}, in_idx, 2);
    check({name, "_bytes_out"}, out_idx, 2);
    check({name, "_scan_enable_cycles"}, se_cnt, ese);
    check({name, "_final_image"}, cur_chain, eimg);
    for (int k = 0; k < 3; k++) begin
      check({name, "_idle_after_done"}, {busy, cpu_hold, done, scan_enable}, 4'b0000);
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic        s;
    logic [15:0] pre;
    logic [15:0] img;
    int          in_stall;
    int          out_stall;
    bit          poke;
    logic [7:0]  e0;
    logic [7:0]  e1;
    logic [15:0] eimg;
    int          ese;
    int          edone;
  } vec_t;

  vec_t vecs [5];
  logic        r_s;
  logic [15:0] r_pre, r_img, r_mask, r_old;
  int          r_len;
  int          k_se;

  initial begin
    vecs[0] = '{1'b0, 16'hBEEF, 16'h1234, 0, 0, 1'b0, 8'hEF, 8'hBE, 16'h1234, 16, 21};
    vecs[1] = '{1'b1, 16'h0A5C, 16'h03FF, 0, 0, 1'b0, 8'h5C, 8'h0A, 16'h03FF, 12, 17};
    vecs[2] = '{1'b0, 16'h1234, 16'hCAFE, 5, 7, 1'b0, 8'h34, 8'h12, 16'hCAFE, 16, 45};
    vecs[3] = '{1'b0, 16'hCAFE, 16'h5A3C, 0, 0, 1'b1, 8'hFE, 8'hCA, 16'h5A3C, 16, 21};
    vecs[4] = '{1'b1, 16'h03FF, 16'h0C81, 2, 1, 1'b0, 8'hFF, 8'h03, 16'h0C81, 12, 23};

    checks = 0; errors = 0;
    sel = 0; start = 0; in_data = 0; in_valid = 0; out_ready = 0;
    load_req = 0; load_val = 0;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      #1;
      check("reset_ctrl", {busy, cpu_hold, done, in_ready, out_valid, scan_enable, scan_in}, 7'b0);
      check("reset_out_data", out_data, 8'h00);
    end
    sel = 0;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      run_session(vecs[i].s, vecs[i].pre, vecs[i].img, vecs[i].in_stall, vecs[i].out_stall,
                  vecs[i].poke, 1'b0, vecs[i].e0, vecs[i].e1, vecs[i].eimg,
                  vecs[i].ese, vecs[i].edone, $sformatf("vec%0d", i));
    end

    // Asynchronous reset landing on shift cycle 3 of the first byte
    sel = 0;
    preload(16'h0F0F);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    k_se = 0;
    for (int c = 0; c < 20 && k_se < 4; c++) begin
      in_valid = in_ready;
      in_data = 8'h99;
      if (scan_enable) k_se++;
      if (k_se < 4) begin
        @(posedge clk); #1;
      end
    end
    in_valid = 0;
    check("midreset_reached_shift3", k_se, 4);
    rst = 1;
    #1;
    check("midreset_async_drop", {busy, cpu_hold, scan_enable, scan_in, in_ready, out_valid}, 6'b0);
    check("midreset_out_data", out_data, 8'h00);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    run_session(1'b0, 16'h8001, 16'h7E42, 0, 0, 1'b0, 1'b0, 8'h01, 8'h80, 16'h7E42, 16, 21,
                "after_reset");

    // Random sessions with random valid/ready; expectations from the exchange rule
    for (int r = 0; r < 8; r++) begin
      r_s    = 1'($urandom_range(0, 1));
      r_len  = r_s ? 12 : 16;
      r_mask = 16'((32'd1 << r_len) - 32'd1);
      r_pre  = 16'($urandom);
      r_img  = 16'($urandom);
      r_old  = r_pre & r_mask;
      run_session(r_s, r_pre, r_img, 0, 0, 1'b0, 1'b1, r_old[7:0], r_old[15:8],
                  r_img & r_mask, r_len, -1, $sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
